// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher job controller: block/key widths,
// operation codes and the controller state encoding.
package cipher_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 128;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Requester blocks are packed side by side: id 0 in the low half.
  function automatic logic [BLK_W-1:0] pick_block(input logic [2*BLK_W-1:0] data,
                                                  input logic id);
    return id ? data[2*BLK_W-1:BLK_W] : data[BLK_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the preferred requester and
// moves to the other one when the owner of a job finishes.
module rr_arb2 (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (done) begin
      ptr_d = ~done_id;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (req[ptr_q]) begin
      gnt_id      = ptr_q;
      gnt[ptr_q]  = 1'b1;
    end else if (req[~ptr_q]) begin
      gnt_id      = ~ptr_q;
      gnt[~ptr_q] = 1'b1;
    end
  end

endmodule

// File: rtl/cipher_job_ctrl.sv
// Runs one encrypt/decrypt job at a time on the shared cipher cores, holding
// the core valid for its fixed latency and returning the result on a
// valid/ready response port. Also owns the key register feeding both cores.
module cipher_job_ctrl
  import cipher_pkg::*;
#(
  parameter int CORE_LAT = 13,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               key_wr,
  input  logic [KEY_W-1:0]   key_in,
  output logic               key_ready,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_op,
  input  logic [2*BLK_W-1:0] req_data,
  output logic [1:0]         req_ready,
  output logic [BLK_W-1:0]   core_din,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_enc_vld,
  output logic               core_dec_vld,
  input  logic [BLK_W-1:0]   core_enc_dout,
  input  logic [BLK_W-1:0]   core_dec_dout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BLK_W-1:0]   rsp_data,
  output logic               rsp_id,
  output logic               busy,
  output logic [CNT_W-1:0]   job_cnt
);

  localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT - 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              op_q, op_d;
  logic              id_q, id_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [BLK_W-1:0]  rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  job_cnt_q, job_cnt_d;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       in_idle;
  logic       accept;
  logic       rsp_fire;

  assign in_idle  = (state_q == ST_IDLE);
  // A key write in IDLE takes the cycle; the job waits one cycle.
  assign accept   = in_idle && !key_wr && (gnt != 2'b00);
  assign rsp_fire = (state_q == ST_DONE) && rsp_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .clr     (clr),
    .req     (req_valid),
    .done    (rsp_fire),
    .done_id (id_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)           state_d = ST_RUN;
      ST_RUN:  if (lat_q == '0)      state_d = ST_DONE;
      ST_DONE: if (rsp_ready)        state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy         = (state_q != ST_IDLE);
    key_ready    = in_idle;
    req_ready    = accept ? gnt : 2'b00;
    core_enc_vld = (state_q == ST_RUN) && (op_q == OP_ENC);
    core_dec_vld = (state_q == ST_RUN) && (op_q == OP_DEC);
    rsp_valid    = (state_q == ST_DONE);
  end

  // Job, key and result registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      lat_q      <= '0;
      blk_q      <= '0;
      op_q       <= OP_ENC;
      id_q       <= 1'b0;
      key_q      <= '0;
      rsp_data_q <= '0;
      job_cnt_q  <= '0;
    end else begin
      lat_q      <= lat_d;
      blk_q      <= blk_d;
      op_q       <= op_d;
      id_q       <= id_d;
      key_q      <= key_d;
      rsp_data_q <= rsp_data_d;
      job_cnt_q  <= job_cnt_d;
    end
  end

  always_comb begin
    lat_d      = lat_q;
    blk_d      = blk_q;
    op_d       = op_q;
    id_d       = id_q;
    key_d      = key_q;
    rsp_data_d = rsp_data_q;
    job_cnt_d  = job_cnt_q;

    if (in_idle && key_wr) begin
      key_d = key_in;
    end

    if (accept) begin
      blk_d = pick_block(req_data, gnt_id);
      op_d  = req_op[gnt_id];
      id_d  = gnt_id;
      lat_d = LAT_LOAD;
    end

    // The last RUN cycle is the one in which the core output is valid.
    if (state_q == ST_RUN) begin
      if (lat_q != '0) begin
        lat_d = lat_q - LAT_W'(1);
      end else begin
        rsp_data_d = (op_q == OP_DEC) ? core_dec_dout : core_enc_dout;
      end
    end

    if (rsp_fire) begin
      job_cnt_d = job_cnt_q + CNT_W'(1);
    end
  end

  assign core_din = blk_q;
  assign core_key = key_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;
  assign job_cnt  = job_cnt_q;

endmodule

// File: doc/cipher_job_ctrl.md
Name: cipher_job_ctrl

Overview:
- Sequences the shared 64-bit-block, 128-bit-key encrypt and decrypt cores.
- Two requesters submit jobs, each an operation (encrypt or decrypt) plus one 64-bit block. The controller arbitrates between them round-robin and runs one job at a time.
- It holds the core's valid input for the core's fixed latency, captures the result and returns it through a valid/ready response port.
- It also owns the 128-bit key register that feeds both cores.

Parameters:
- CORE_LAT, 13: cycles the core valid input must be held before its output is valid (≥1).
- CNT_W, 16: width of the completed-job counter.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-low reset
- key_wr  in  1  key write strobe
- key_in  in  128  new key
- key_ready  out  1  key write accepted this cycle
- req_valid  in  2  per-requester job valid
- req_op  in  2  per-requester operation, 0=encrypt, 1=decrypt
- req_data  in  128  per-requester block; [63:0]=req0, [127:64]=req1
- req_ready  out  2  one-hot job accept
- core_din  out  64  block to both cores
- core_key  out  128  key to both cores
- core_enc_vld  out  1  encrypt core valid
- core_dec_vld  out  1  decrypt core valid
- core_enc_dout  in  64  encrypt core result
- core_dec_dout  in  64  decrypt core result
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_data  out  64  result block
- rsp_id  out  1  requester that owns the result
- busy  out  1  high in any state other than IDLE
- job_cnt  out  CNT_W  count of completed jobs

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; rr pointer=0; key register=0; all outputs 0, including core_din, core_*_vld, rsp_*, req_ready and job_cnt.
- States: IDLE, RUN, DONE.
- key_ready=1 only in IDLE. A key write takes effect on that edge.
- In IDLE, key_wr=1 has priority: req_ready=0 that cycle.
- IDLE with no key_wr and any req_valid: grant the requester equal to the rr pointer if it is valid, else the other one.
  - req_ready is combinational and one-hot, for the granted requester only.
  - On the edge, latch data, op and id; load down-counter with CORE_LAT-1; go to RUN.
- RUN:
  - core_din holds the latched block.
  - core_enc_vld=1 when op=0; core_dec_vld=1 when op=1. The other valid is 0.
  - Both held for exactly CORE_LAT cycles.
  - When counter=0: capture the selected core output into rsp_data, drop valids, go to DONE.
  - core_din and core_key must not change during RUN.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id stable until rsp_ready=1.
  - On the rsp_valid&rsp_ready edge: rsp_valid→0; job_cnt+1 (wraps at 2^CNT_W); rr pointer = !rsp_id; go to IDLE.
  - No job is accepted in the same cycle as the DONE exit.
- Latency: request accepted at edge T → core valid high over cycles T+1..T+CORE_LAT → rsp_valid high from T+CORE_LAT+1. A single stream has throughput of one job per CORE_LAT+2 cycles.
- Back-pressure: rsp_ready may stay low indefinitely. The controller stays in DONE, req_ready=0 and key_ready=0.
- Both requesters valid continuously: grants strictly alternate.
- Reset mid-RUN or mid-DONE: the job is discarded, with no response and no job_cnt increment. The key returns to 0.
- req_valid dropping while not granted is legal. A requester must hold valid and data until it sees req_ready.

Decomposition:
- Shared package cipher_pkg: block width 64, key width 128, OP_ENC=0 / OP_DEC=1, state encoding.
- One sub-module, rr_arb2: a 2-way round-robin grant with pointer update on completion.

Test Plan:
- Reset/idle: hold clr=0 for 100 ns then release; no requests → all outputs 0, busy=0, key_ready=1.
- Encrypt known vector: key 128'h1; req0 encrypt 64'h0 → rsp_data=64'heedba5216d8f4b15, rsp_id=0. rsp_valid rises exactly CORE_LAT+1 cycles after accept; job_cnt=1.
- Decrypt known vector: key 128'h1; req1 decrypt 64'heedba5216d8f4b15 → rsp_data=64'h0, rsp_id=1. core_enc_vld never asserts.
- Contention plus back-pressure: both requesters valid continuously with rsp_ready low for 10 cycles per response.
  - Grants are ordered 0,1,0,1.
  - Results stay stable while stalled.
  - req_ready and key_ready stay 0 while stalled.
- Key priority: key_wr and req_valid asserted together in IDLE → key accepted and req_ready=0 that cycle; job accepted the next cycle using the new key. A key_wr during RUN is ignored (key_ready=0).
- Reset mid-operation: assert clr=0 in RUN cycle 5 → rsp_valid never rises; state IDLE; job_cnt unchanged at 0; key reads 0.
